// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver.
//   state_t : receiver FSM states
//   OS_RATE : s_tick strobes per bit period
//   OS_MID  : s_tick count that marks the middle of the start bit
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        WAIT_HI
    } state_t;

    localparam int OS_RATE = 16;
    localparam int OS_MID  = 7;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
// Both flops reset to 1, which is the idle line level.
//   clk   in  system clock
//   reset in  asynchronous, active-high
//   rx    in  raw serial line
//   rx_s  out synchronised serial line (2 clk latency)
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            meta <= rx;
            rx_s <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver (16x baud s_tick from an external mod-M counter).
// Receives start, DBIT data bits LSB-first, optional parity, then stop field.
//   clk          in  system clock
//   reset        in  asynchronous, active-high
//   rx           in  serial line, idle high, asynchronous to clk
//   s_tick       in  one-clk strobe at 16x baud
//   dout         out received word, LSB = first bit received
//   rx_done_tick out one-clk pulse when a frame completes
//   frame_err    out stop bit sampled low on the last completed frame
//   parity_err   out parity mismatch on the last completed frame
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err
);

    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;
    // Tick counter is 4 bits for the normal case; widened only so that
    // 1.5/2 stop-bit settings (SB_TICK up to 32) can still be counted.
    localparam int S_W = (SB_TICK > OS_RATE) ? $clog2(SB_TICK) : 4;

    localparam logic [S_W-1:0] S_MID  = S_W'(OS_MID);
    localparam logic [S_W-1:0] S_LAST = S_W'(OS_RATE - 1);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);

    logic rx_s;

    state_t          state, state_next;
    logic [S_W-1:0]  s, s_next;
    logic [N_W-1:0]  n, n_next;
    logic [DBIT-1:0] b, b_next;
    logic            p, p_next;
    logic            frame_done;

    logic [DBIT-1:0] dout_next;
    logic            done_next;
    logic            frame_err_next;
    logic            parity_err_next;
    logic            par_mismatch;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .rx_s  (rx_s)
    );

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            p            <= 1'b0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            parity_err   <= 1'b0;
        end else begin
            state        <= state_next;
            s            <= s_next;
            n            <= n_next;
            b            <= b_next;
            p            <= p_next;
            dout         <= dout_next;
            rx_done_tick <= done_next;
            frame_err    <= frame_err_next;
            parity_err   <= parity_err_next;
        end
    end

    // Next-state and datapath logic. Only IDLE reacts without s_tick.
    always_comb begin
        state_next = state;
        s_next     = s;
        n_next     = n;
        b_next     = b;
        p_next     = p;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s == S_MID) begin
                        s_next = '0;
                        if (!rx_s) begin
                            state_next = DATA;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s == S_LAST) begin
                        s_next = '0;
                        b_next = {rx_s, b[DBIT-1:1]};
                        if (n == N_LAST) begin
                            state_next = (PARITY_EN != 0) ? PAR : STOP;
                        end else begin
                            n_next = n + 1'b1;
                        end
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            PAR: begin
                if (s_tick) begin
                    if (s == S_LAST) begin
                        s_next     = '0;
                        p_next     = rx_s;
                        state_next = STOP;
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s == S_STOP) begin
                        s_next     = '0;
                        frame_done = 1'b1;
                        state_next = rx_s ? IDLE : WAIT_HI;
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            WAIT_HI: begin
                // A held-low line (break) must return high before re-arming.
                if (s_tick && rx_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output update: word and flags load together with the done pulse.
    always_comb begin
        par_mismatch    = (PARITY_EN != 0) && ((^b) ^ p ^ (PARITY_ODD != 0));
        done_next       = frame_done;
        dout_next       = frame_done ? b : dout;
        frame_err_next  = frame_done ? ~rx_s : frame_err;
        parity_err_next = frame_done ? par_mismatch : parity_err;
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed self-checking bench for uart_rx_os.
// Two instances: default framing (8N1) and even parity (8E1), each fed
// from its own line; s_tick comes from a mod-4 counter so 1 bit = 64 clk.
module tb_uart_rx_os;

    logic clk = 1'b0;
    logic reset;
    logic line;
    logic use_b;
    logic rx_a, rx_b;
    logic s_tick;
    logic [1:0] bcnt;

    logic [7:0] dout_a, dout_b;
    logic       done_a, done_b;
    logic       fe_a, fe_b;
    logic       pe_a, pe_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frame_start_cyc = 0;
    int done_cyc_a = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    int width_err = 0;
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;
    logic [7:0] cap_a[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge reset) begin
        if (reset) bcnt <= '0;
        else       bcnt <= bcnt + 2'd1;
    end
    assign s_tick = (bcnt == 2'd3);

    assign rx_a = use_b ? 1'b1 : line;
    assign rx_b = use_b ? line : 1'b1;

    uart_rx_os dut_a (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx_a),
        .s_tick       (s_tick),
        .dout         (dout_a),
        .rx_done_tick (done_a),
        .frame_err    (fe_a),
        .parity_err   (pe_a)
    );

    uart_rx_os #(.PARITY_EN(1), .PARITY_ODD(0)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx_b),
        .s_tick       (s_tick),
        .dout         (dout_b),
        .rx_done_tick (done_b),
        .frame_err    (fe_b),
        .parity_err   (pe_b)
    );

    always @(negedge clk) begin
        if (done_a) begin
            if (prev_a) width_err++;
            done_cnt_a++;
            done_cyc_a = cyc;
            cap_a.push_back(dout_a);
        end
        if (done_b) begin
            if (prev_b) width_err++;
            done_cnt_b++;
        end
        prev_a = done_a;
        prev_b = done_b;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bit_time();
        repeat (64) @(negedge clk);
    endtask

    task automatic send_frame(input logic [8:0] data, input int nbits, input bit with_par,
                              input logic par_bit, input logic stop_bit);
        frame_start_cyc = cyc;
        line = 1'b0;
        bit_time();
        for (int i = 0; i < nbits; i++) begin
            line = data[i];
            bit_time();
        end
        if (with_par) begin
            line = par_bit;
            bit_time();
        end
        line = stop_bit;
        bit_time();
        line = 1'b1;
    endtask

    initial begin
        int base;
        int lat;
        reset = 1'b1;
        line  = 1'b1;
        use_b = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_dout", 32'(dout_a), 32'h0);
        check("rst_done", 32'(done_a), 32'h0);
        check("rst_fe", 32'(fe_a), 32'h0);
        check("rst_pe", 32'(pe_a), 32'h0);
        repeat (2) bit_time();

        // 0xA5, good stop
        base = done_cnt_a;
        send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1);
        lat = done_cyc_a - frame_start_cyc;
        repeat (2) bit_time();
        check("a5_count", 32'(done_cnt_a - base), 32'd1);
        check("a5_dout", 32'(dout_a), 32'hA5);
        check("a5_fe", 32'(fe_a), 32'h0);
        check("a5_pe", 32'(pe_a), 32'h0);
        check("a5_latency", 32'(lat >= 600 && lat <= 620), 32'd1);

        // Start glitch of 3 s_ticks
        base = done_cnt_a;
        line = 1'b0;
        repeat (12) @(negedge clk);
        line = 1'b1;
        repeat (2) bit_time();
        check("glitch_count", 32'(done_cnt_a - base), 32'd0);
        check("glitch_dout", 32'(dout_a), 32'hA5);

        // Even parity: 0x07 has three ones, so parity bit 1 is correct
        use_b = 1'b1;
        base = done_cnt_b;
        send_frame(9'h007, 8, 1'b1, 1'b1, 1'b1);
        repeat (2) bit_time();
        check("par_good_count", 32'(done_cnt_b - base), 32'd1);
        check("par_good_dout", 32'(dout_b), 32'h07);
        check("par_good_pe", 32'(pe_b), 32'h0);
        check("par_good_fe", 32'(fe_b), 32'h0);
        send_frame(9'h007, 8, 1'b1, 1'b0, 1'b1);
        repeat (2) bit_time();
        check("par_bad_count", 32'(done_cnt_b - base), 32'd2);
        check("par_bad_pe", 32'(pe_b), 32'h1);
        use_b = 1'b0;

        // Framing error followed by a break of 40 bit-times
        base = done_cnt_a;
        send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b0);
        line = 1'b0;
        repeat (40) bit_time();
        check("brk_count", 32'(done_cnt_a - base), 32'd1);
        check("brk_dout", 32'(dout_a), 32'h3C);
        check("brk_fe", 32'(fe_a), 32'h1);
        line = 1'b1;
        repeat (2) bit_time();
        check("brk_release_count", 32'(done_cnt_a - base), 32'd1);
        send_frame(9'h055, 8, 1'b0, 1'b0, 1'b1);
        repeat (2) bit_time();
        check("post_brk_count", 32'(done_cnt_a - base), 32'd2);
        check("post_brk_dout", 32'(dout_a), 32'h55);
        check("post_brk_fe", 32'(fe_a), 32'h0);

        // Back-to-back frames, then reset partway into a third
        base = done_cnt_a;
        send_frame(9'h012, 8, 1'b0, 1'b0, 1'b1);
        send_frame(9'h034, 8, 1'b0, 1'b0, 1'b1);
        line = 1'b0;
        bit_time();
        line = 1'b0;
        bit_time();
        line = 1'b1;
        repeat (32) @(negedge clk);
        check("b2b_count", 32'(done_cnt_a - base), 32'd2);
        check("b2b_first", 32'(cap_a[base]), 32'h12);
        check("b2b_second", 32'(cap_a[base + 1]), 32'h34);
        reset = 1'b1;
        line  = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_dout", 32'(dout_a), 32'h0);
        check("mid_rst_done", 32'(done_a), 32'h0);
        check("mid_rst_fe", 32'(fe_a), 32'h0);
        check("mid_rst_pe", 32'(pe_a), 32'h0);
        repeat (12) bit_time();
        check("mid_rst_no_done", 32'(done_cnt_a - base), 32'd2);
        check("mid_rst_dout_hold", 32'(dout_a), 32'h0);

        check("done_width", 32'(width_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
